// File: rtl/core_pkg.sv
// Shared core definitions used by the memory port arbiter: FSM state
// encoding, owner identifiers and the default hang-timeout length.
package core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_BUSY_IF = 2'b01,
    ARB_BUSY_LS = 2'b10
  } arb_state_e;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_LS = 1'b1;

  localparam int ARB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts busy cycles without an acknowledge and flags the cycle in which
// an access has to be aborted. TIMEOUT = 0 disables expiry entirely.
module arb_timeout_cnt
  import core_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic ip_clk,
  input  logic ip_rst,
  input  logic ip_clear,
  input  logic ip_enable,
  output logic op_expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  // Wait counter: restarts whenever the arbiter is idle, advances per unacked busy cycle.
  always_ff @(posedge ip_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (ip_rst || ip_clear) r_cnt <= '0;
    else if (ip_enable)     r_cnt <= r_cnt + CW'(1);
  end

  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign op_expire = 1'b0;
    end else begin : g_timeout
      assign op_expire = ip_enable && (r_cnt == LAST);
    end
  endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch (IF) and
// load/store (LS). Load/store has priority; when the ARB_FETCH_FAIRNESS_EN
// macro is defined, a fetch that lost to a load/store wins the next contest.
// The memory request is held until acknowledged and hung accesses are
// aborted with an error after TIMEOUT busy cycles.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                ip_clk,
  input  logic                ip_rst,
  input  logic                ip_if_req,
  input  logic [ADDR_W-1:0]   ip_if_addr,
  output logic                op_if_done,
  output logic [DATA_W-1:0]   op_if_rdata,
  output logic                op_if_err,
  input  logic                ip_ls_req,
  input  logic                ip_ls_we,
  input  logic [DATA_W/8-1:0] ip_ls_be,
  input  logic [ADDR_W-1:0]   ip_ls_addr,
  input  logic [DATA_W-1:0]   ip_ls_wdata,
  output logic                op_ls_done,
  output logic [DATA_W-1:0]   op_ls_rdata,
  output logic                op_ls_err,
  output logic                op_mem_req,
  output logic                op_mem_we,
  output logic [DATA_W/8-1:0] op_mem_be,
  output logic [ADDR_W-1:0]   op_mem_addr,
  output logic [DATA_W-1:0]   op_mem_wdata,
  input  logic                ip_mem_ack,
  input  logic [DATA_W-1:0]   ip_mem_rdata
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [BE_W-1:0]   r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_busy;
  logic w_expire;
  logic w_finish;
  logic w_owner;
  logic w_ls_wins;
  logic w_grant_if;
  logic w_grant_ls;

`ifdef ARB_FETCH_FAIRNESS_EN
  logic r_fair;

  assign w_ls_wins = ip_ls_req && !(r_fair && ip_if_req);

  // Fairness flag: owed a fetch turn after LS beat a waiting fetch.
  always_ff @(posedge ip_clk) begin
    if (ip_rst)                      r_fair <= 1'b0;
    else if (w_grant_ls && ip_if_req) r_fair <= 1'b1;
    else if (w_grant_if)             r_fair <= 1'b0;
  end
`else
  assign w_ls_wins = ip_ls_req;
`endif

  assign w_busy   = (r_state != ARB_IDLE);
  assign w_finish = w_busy && (ip_mem_ack || w_expire);
  assign w_owner  = (r_state == ARB_BUSY_LS) ? OWNER_LS : OWNER_IF;

  arb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .ip_clk    (ip_clk),
    .ip_rst    (ip_rst),
    .ip_clear  (!w_busy),
    .ip_enable (w_busy && !ip_mem_ack),
    .op_expire (w_expire)
  );

  // Next-state selection, grant decode and per-requester completion outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    w_next      = r_state;
    w_grant_if  = 1'b0;
    w_grant_ls  = 1'b0;
    op_if_done  = 1'b0;
    op_if_err   = 1'b0;
    op_if_rdata = '0;
    op_ls_done  = 1'b0;
    op_ls_err   = 1'b0;
    op_ls_rdata = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_ls_wins) begin
          w_next     = ARB_BUSY_LS;
          w_grant_ls = 1'b1;
        end else if (ip_if_req) begin
          w_next     = ARB_BUSY_IF;
          w_grant_if = 1'b1;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_LS: begin
        if (w_finish) w_next = ARB_IDLE;
        if (w_owner == OWNER_IF) begin
          op_if_done  = w_finish;
          op_if_err   = w_finish && !ip_mem_ack;
          op_if_rdata = ip_mem_ack ? ip_mem_rdata : '0;
        end else begin
          op_ls_done  = w_finish;
          op_ls_err   = w_finish && !ip_mem_ack;
          op_ls_rdata = ip_mem_ack ? ip_mem_rdata : '0;
        end
      end
      default: w_next = ARB_IDLE;
    endcase
  end

  // State register and registered memory request, loaded from the winner on grant.
  always_ff @(posedge ip_clk) begin
    if (ip_rst) begin
      r_state     <= ARB_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_ls) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= ip_ls_we;
        r_mem_be    <= ip_ls_be;
        r_mem_addr  <= ip_ls_addr;
        r_mem_wdata <= ip_ls_wdata;
      end else if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_be    <= '1;
        r_mem_addr  <= ip_if_addr;
        r_mem_wdata <= '0;
      end else if (w_finish) begin
        r_mem_req   <= 1'b0;
      end
    end
  end

  assign op_mem_req   = r_mem_req;
  assign op_mem_we    = r_mem_we;
  assign op_mem_be    = r_mem_be;
  assign op_mem_addr  = r_mem_addr;
  assign op_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized requesters and memory checked against a transaction-level model.
// Expectations follow ARB_FETCH_FAIRNESS_EN when the macro is defined.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 16;
`ifdef ARB_FETCH_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          ip_clk;
  logic          ip_rst;
  logic          ip_if_req;
  logic [AW-1:0] ip_if_addr;
  logic          op_if_done;
  logic [DW-1:0] op_if_rdata;
  logic          op_if_err;
  logic          ip_ls_req;
  logic          ip_ls_we;
  logic [BW-1:0] ip_ls_be;
  logic [AW-1:0] ip_ls_addr;
  logic [DW-1:0] ip_ls_wdata;
  logic          op_ls_done;
  logic [DW-1:0] op_ls_rdata;
  logic          op_ls_err;
  logic          op_mem_req;
  logic          op_mem_we;
  logic [BW-1:0] op_mem_be;
  logic [AW-1:0] op_mem_addr;
  logic [DW-1:0] op_mem_wdata;
  logic          ip_mem_ack;
  logic [DW-1:0] ip_mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .ip_clk       (ip_clk),
    .ip_rst       (ip_rst),
    .ip_if_req    (ip_if_req),
    .ip_if_addr   (ip_if_addr),
    .op_if_done   (op_if_done),
    .op_if_rdata  (op_if_rdata),
    .op_if_err    (op_if_err),
    .ip_ls_req    (ip_ls_req),
    .ip_ls_we     (ip_ls_we),
    .ip_ls_be     (ip_ls_be),
    .ip_ls_addr   (ip_ls_addr),
    .ip_ls_wdata  (ip_ls_wdata),
    .op_ls_done   (op_ls_done),
    .op_ls_rdata  (op_ls_rdata),
    .op_ls_err    (op_ls_err),
    .op_mem_req   (op_mem_req),
    .op_mem_we    (op_mem_we),
    .op_mem_be    (op_mem_be),
    .op_mem_addr  (op_mem_addr),
    .op_mem_wdata (op_mem_wdata),
    .ip_mem_ack   (ip_mem_ack),
    .ip_mem_rdata (ip_mem_rdata)
  );

  initial ip_clk = 1'b0;
  always #5 ip_clk = ~ip_clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge ip_clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    ip_if_req    = 1'b0;
    ip_if_addr   = '0;
    ip_ls_req    = 1'b0;
    ip_ls_we     = 1'b0;
    ip_ls_be     = '0;
    ip_ls_addr   = '0;
    ip_ls_wdata  = '0;
    ip_mem_ack   = 1'b0;
    ip_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ip_rst = 1'b1;
    tick();
    tick();
    ip_rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [149:0] got;
    do_reset();
    settle();
    got = {op_if_done, op_if_err, op_if_rdata, op_ls_done, op_ls_err, op_ls_rdata,
           op_mem_req, op_mem_we, op_mem_be, op_mem_addr, op_mem_wdata};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h exp 0", got);
    end
  endtask

  task automatic test_if_single();
    do_reset();
    ip_if_req  = 1'b1;
    ip_if_addr = 32'h0000_0010;
    settle();
    n_tests++;
    if (op_mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL if_single_req_early got %b exp 0", op_mem_req);
    end
    tick();
    ip_mem_ack   = 1'b1;
    ip_mem_rdata = 32'h0051_3093;
    settle();
    n_tests++;
    if ({op_mem_req, op_mem_we, op_mem_be, op_mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
      n_fail++;
      $display("FAIL if_single_mem got %b %b %h %h exp 1 0 f 00000010",
               op_mem_req, op_mem_we, op_mem_be, op_mem_addr);
    end
    n_tests++;
    if ({op_if_done, op_if_err, op_if_rdata, op_ls_done} !== {1'b1, 1'b0, 32'h0051_3093, 1'b0}) begin
      n_fail++;
      $display("FAIL if_single_done got done=%b err=%b rdata=%h ls_done=%b exp 1 0 00513093 0",
               op_if_done, op_if_err, op_if_rdata, op_ls_done);
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if ({op_mem_req, op_if_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL if_single_release got req=%b done=%b exp 0 0", op_mem_req, op_if_done);
    end
  endtask

  task automatic test_priority();
    logic [AW-1:0] exp_addr;
    do_reset();
    ip_if_req   = 1'b1;
    ip_if_addr  = 32'h20;
    ip_ls_req   = 1'b1;
    ip_ls_we    = 1'b1;
    ip_ls_be    = 4'hF;
    ip_ls_addr  = 32'h100;
    ip_ls_wdata = 32'hDEAD_BEEF;
    tick();
    ip_mem_ack = 1'b1;
    settle();
    n_tests++;
    if ({op_mem_req, op_mem_we, op_mem_addr, op_mem_wdata, op_ls_done, op_if_done}
        !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_ls_first got req=%b we=%b addr=%h wdata=%h ls_done=%b if_done=%b",
               op_mem_req, op_mem_we, op_mem_addr, op_mem_wdata, op_ls_done, op_if_done);
    end
    tick();
    ip_ls_req  = 1'b0;
    ip_mem_ack = 1'b0;
    tick();
    ip_mem_ack = 1'b1;
    settle();
    n_tests++;
    if ({op_mem_req, op_mem_we, op_mem_addr, op_if_done, op_ls_done}
        !== {1'b1, 1'b0, 32'h20, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL prio_if_after got req=%b we=%b addr=%h if_done=%b ls_done=%b",
               op_mem_req, op_mem_we, op_mem_addr, op_if_done, op_ls_done);
    end
    // Second contest: LS wins, then re-requests immediately while IF still waits.
    tick();
    ip_mem_ack = 1'b0;
    ip_if_addr = 32'h24;
    ip_ls_req  = 1'b1;
    ip_ls_we   = 1'b0;
    ip_ls_addr = 32'h200;
    tick();
    ip_mem_ack = 1'b1;
    settle();
    n_tests++;
    if ({op_mem_addr, op_ls_done} !== {32'h200, 1'b1}) begin
      n_fail++;
      $display("FAIL prio_second_ls got addr=%h ls_done=%b exp 00000200 1", op_mem_addr, op_ls_done);
    end
    tick();
    ip_mem_ack = 1'b0;
    ip_ls_addr = 32'h204;
    tick();
    ip_mem_ack = 1'b1;
    settle();
    exp_addr = FAIR ? 32'h24 : 32'h204;
    n_tests++;
    if ({op_mem_addr, op_if_done, op_ls_done} !== {exp_addr, FAIR, !FAIR}) begin
      n_fail++;
      $display("FAIL prio_fairness got addr=%h if_done=%b ls_done=%b exp %h %b %b",
               op_mem_addr, op_if_done, op_ls_done, exp_addr, FAIR, !FAIR);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_ls_delayed_ack();
    do_reset();
    ip_ls_req  = 1'b1;
    ip_ls_we   = 1'b0;
    ip_ls_be   = 4'b0011;
    ip_ls_addr = 32'h300;
    tick();
    for (int k = 0; k < 5; k++) begin
      settle();
      n_tests++;
      if ({op_mem_req, op_mem_addr, op_mem_be, op_ls_done} !== {1'b1, 32'h300, 4'b0011, 1'b0}) begin
        n_fail++;
        $display("FAIL ls_wait_%0d got req=%b addr=%h be=%h done=%b", k,
                 op_mem_req, op_mem_addr, op_mem_be, op_ls_done);
      end
      tick();
    end
    ip_mem_ack   = 1'b1;
    ip_mem_rdata = 32'hCAFE_0001;
    settle();
    n_tests++;
    if ({op_ls_done, op_ls_err, op_ls_rdata} !== {1'b1, 1'b0, 32'hCAFE_0001}) begin
      n_fail++;
      $display("FAIL ls_delayed_done got done=%b err=%b rdata=%h exp 1 0 cafe0001",
               op_ls_done, op_ls_err, op_ls_rdata);
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if ({op_ls_done, op_mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL ls_single_pulse got done=%b req=%b exp 0 0", op_ls_done, op_mem_req);
    end
  endtask

  task automatic test_timeout();
    int            found;
    logic          got_err;
    logic [DW-1:0] got_rdata;
    do_reset();
    found      = 0;
    got_err    = 1'b0;
    got_rdata  = '1;
    ip_ls_req  = 1'b1;
    ip_ls_addr = 32'h400;
    ip_ls_be   = 4'hF;
    ip_mem_rdata = 32'h5555_AAAA;
    tick();
    for (int k = 1; k <= 40; k++) begin
      settle();
      if (op_ls_done === 1'b1) begin
        found     = k;
        got_err   = op_ls_err;
        got_rdata = op_ls_rdata;
        break;
      end
      tick();
    end
    n_tests++;
    if (found != TO) begin
      n_fail++;
      $display("FAIL timeout_cycle got busy cycle %0d exp %0d", found, TO);
    end
    n_tests++;
    if ({got_err, got_rdata} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL timeout_err got err=%b rdata=%h exp 1 00000000", got_err, got_rdata);
    end
    tick();
    ip_ls_req = 1'b0;
    settle();
    n_tests++;
    if ({op_mem_req, op_ls_done, op_ls_err} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_idle got req=%b done=%b err=%b exp 0 0 0", op_mem_req, op_ls_done, op_ls_err);
    end
  endtask

  task automatic test_reset_mid();
    logic [149:0] got;
    do_reset();
    ip_if_req  = 1'b1;
    ip_if_addr = 32'h500;
    tick();
    tick();
    ip_if_req = 1'b0;
    ip_rst    = 1'b1;
    tick();
    ip_rst = 1'b0;
    settle();
    got = {op_if_done, op_if_err, op_if_rdata, op_ls_done, op_ls_err, op_ls_rdata,
           op_mem_req, op_mem_we, op_mem_be, op_mem_addr, op_mem_wdata};
    n_tests++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs got %h exp 0", got);
    end
    ip_mem_ack = 1'b1;
    settle();
    n_tests++;
    if (op_if_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done got %b exp 0", op_if_done);
    end
    tick();
    ip_mem_ack   = 1'b0;
    ip_if_req    = 1'b1;
    ip_if_addr   = 32'h600;
    tick();
    ip_mem_ack   = 1'b1;
    ip_mem_rdata = 32'h0000_1234;
    settle();
    n_tests++;
    if ({op_mem_addr, op_if_done, op_if_rdata} !== {32'h600, 1'b1, 32'h1234}) begin
      n_fail++;
      $display("FAIL reset_mid_recover got addr=%h done=%b rdata=%h exp 00000600 1 00001234",
               op_mem_addr, op_if_done, op_if_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] exp_addr;
    do_reset();
    ip_if_req  = 1'b1;
    ip_if_addr = 32'h1000;
    ip_mem_ack = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      ip_mem_rdata = DW'(k);
      settle();
      exp_addr = 32'h1000 + AW'(4 * (k / 2));
      n_tests++;
      if ({op_mem_req, op_if_done} !== {k[0], k[0]} ||
          (k[0] && {op_mem_addr, op_if_rdata} !== {exp_addr, DW'(k)})) begin
        n_fail++;
        $display("FAIL b2b_cycle_%0d got req=%b done=%b addr=%h rdata=%h exp %b %b %h %h", k,
                 op_mem_req, op_if_done, op_mem_addr, op_if_rdata, k[0], k[0], exp_addr, DW'(k));
      end
      tick();
      if (k[0]) ip_if_addr = ip_if_addr + 32'd4;
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit            m_busy, m_own_ls, m_flag;
    int            m_age;
    logic          m_req, m_we;
    logic [BW-1:0] m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          e_if_done, e_ls_done, e_err;
    logic [DW-1:0] e_rdata;
    bit            prev_if_done, prev_ls_done;
    logic [141:0]  exp_v, got_v;
    do_reset();
    m_busy = 0; m_own_ls = 0; m_flag = 0; m_age = 0;
    m_req = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0;
    prev_if_done = 0; prev_ls_done = 0;
    for (int c = 0; c < 500; c++) begin
      // Requesters: hold until done, then keep going or drop.
      if (!ip_if_req ? ($urandom_range(0, 2) == 0) : prev_if_done) begin
        ip_if_req  = !ip_if_req || ($urandom_range(0, 1) == 1);
        ip_if_addr = $urandom;
      end
      if (!ip_ls_req ? ($urandom_range(0, 2) == 0) : prev_ls_done) begin
        ip_ls_req   = !ip_ls_req || ($urandom_range(0, 1) == 1);
        ip_ls_we    = 1'($urandom_range(0, 1));
        ip_ls_be    = BW'($urandom_range(0, 15));
        ip_ls_addr  = $urandom;
        ip_ls_wdata = $urandom;
      end
      ip_mem_ack   = m_busy ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      ip_mem_rdata = $urandom;
      // Expected completion this cycle.
      e_if_done = m_busy && !m_own_ls && (ip_mem_ack || (TO != 0 && m_age == TO));
      e_ls_done = m_busy &&  m_own_ls && (ip_mem_ack || (TO != 0 && m_age == TO));
      e_err     = !ip_mem_ack;
      e_rdata   = ip_mem_ack ? ip_mem_rdata : '0;
      settle();
      exp_v = {m_req, m_we, m_be, m_addr, m_wdata,
               e_if_done, e_if_done && e_err, e_ls_done, e_ls_done && e_err,
               (e_if_done || e_ls_done) ? e_rdata : 32'h0};
      got_v = {op_mem_req, op_mem_we, op_mem_be, op_mem_addr, op_mem_wdata,
               op_if_done, op_if_err, op_ls_done, op_ls_err,
               e_if_done ? op_if_rdata : (e_ls_done ? op_ls_rdata : 32'h0)};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle_%0d got %h exp %h", c, got_v, exp_v);
      end
      // Advance the model by one clock.
      if (m_busy) begin
        if (e_if_done || e_ls_done) begin
          m_busy = 0;
          m_req  = 0;
        end else begin
          m_age++;
        end
      end else if (ip_ls_req && !(FAIR && m_flag && ip_if_req)) begin
        m_busy = 1; m_own_ls = 1; m_age = 1;
        m_req = 1; m_we = ip_ls_we; m_be = ip_ls_be; m_addr = ip_ls_addr; m_wdata = ip_ls_wdata;
        if (ip_if_req) m_flag = 1;
      end else if (ip_if_req) begin
        m_busy = 1; m_own_ls = 0; m_age = 1;
        m_req = 1; m_we = 0; m_be = '1; m_addr = ip_if_addr; m_wdata = '0;
        m_flag = 0;
      end
      prev_if_done = e_if_done;
      prev_ls_done = e_ls_done;
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    ip_rst = 1'b1;
    idle_inputs();
    test_reset();
    test_if_single();
    test_priority();
    test_ls_delayed_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (IF) and load/store (LS).
- Sits between the data path's fetch/LSU stages and the external memory interface.
- Instantiated inside data_path, under RISCV_core.
- Serialises accesses, holds the memory request until acknowledged, returns data/done to the owning requester, and aborts hung accesses with a timeout error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (byte enables are DATA_W/8).
- TIMEOUT, 16, cycles from memory request to abort; 0 disables the timeout.

Ports:
- ip_clk  in  1  core clock
- ip_rst  in  1  synchronous, active-high reset
- ip_if_req  in  1  fetch request, held until op_if_done
- ip_if_addr  in  ADDR_W  fetch address
- op_if_done  out  1  fetch complete pulse
- op_if_rdata  out  DATA_W  fetch data, valid with op_if_done
- op_if_err  out  1  fetch timed out, valid with op_if_done
- ip_ls_req  in  1  load/store request, held until op_ls_done
- ip_ls_we  in  1  1 = store
- ip_ls_be  in  DATA_W/8  byte enables
- ip_ls_addr  in  ADDR_W  data address
- ip_ls_wdata  in  DATA_W  store data
- op_ls_done  out  1  load/store complete pulse
- op_ls_rdata  out  DATA_W  load data
- op_ls_err  out  1  load/store timed out
- op_mem_req  out  1  memory request
- op_mem_we  out  1  memory write enable
- op_mem_be  out  DATA_W/8  memory byte enables
- op_mem_addr  out  ADDR_W  memory address
- op_mem_wdata  out  DATA_W  memory write data
- ip_mem_ack  in  1  memory acknowledge; data valid in same cycle
- ip_mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (ip_clk edge with ip_rst=1): state IDLE, timeout counter 0, fairness flag 0, all op_* 0.
  - Reset mid-transaction abandons the access; no done pulse is issued.
- States: IDLE, BUSY_IF, BUSY_LS.
- IDLE:
  - ip_ls_req=1 → BUSY_LS; else ip_if_req=1 → BUSY_IF; else stay.
  - LS has priority (see optional feature).
  - On entry to BUSY_x, the winner's address, we, be and wdata are registered onto op_mem_*, and op_mem_req is set to 1.
  - For IF: op_mem_we=0 and op_mem_be=all ones.
- BUSY_x:
  - op_mem_req and op_mem_* stay stable until ip_mem_ack.
  - ip_mem_ack=1 → op_x_done=1 combinationally in the same cycle; op_x_rdata=ip_mem_rdata and op_x_err=0. Next state IDLE, op_mem_req cleared.
  - Timeout: counter increments each BUSY cycle without ack. When counter=TIMEOUT-1 and no ack, assert op_x_done=1 and op_x_err=1, rdata=0, then go to IDLE.
  - Ack in the timeout cycle wins: normal completion, err=0.
- Latency:
  - request sampled in IDLE at cycle N → op_mem_req high at N+1.
  - Zero-wait memory acks at N+1 → done at N+1, IDLE at N+2.
  - Minimum 2 cycles per access; back-to-back grants possible every 2 cycles.
- Requester contract: req and payload stable from assertion through the done cycle. After done, the requester may keep req high for its next access.
- Requests arriving while BUSY wait; they are never dropped.
- The non-owner's done/err are always 0, and done is never asserted in IDLE.
- Stores return op_ls_rdata = ip_mem_rdata (don't-care).

Optional Feature:
- Macro: ARB_FETCH_FAIRNESS_EN.
- Defined:
  - A 1-bit flag is set when LS is granted while ip_if_req=1.
  - In IDLE with flag=1 and both requesting, IF wins and the flag clears.
  - Fetch is never starved beyond one LS access.
- Undefined: strict LS priority, no flag logic.

Decomposition:
- Shared package core_pkg holds:
  - state encoding constants ARB_IDLE/ARB_BUSY_IF/ARB_BUSY_LS;
  - owner ID constants;
  - the default TIMEOUT value.
- One sub-module, arb_timeout_cnt:
  - inputs: clear, enable; parameter TIMEOUT.
  - output: expire pulse.
  - Tied off to never expire when TIMEOUT=0.

Test Plan:
- Only IF req, addr 0x0000_0010, mem acks next cycle with 0x0051_3093 → op_mem_req at N+1, op_if_done=1 with rdata 0x0051_3093 at N+1, op_if_err=0.
- IF and LS store (addr 0x100, wdata 0xDEAD_BEEF, be 0xF) requested same cycle → LS granted first with op_mem_we=1; IF granted after LS done; with ARB_FETCH_FAIRNESS_EN and LS re-requesting, IF still goes before the second LS.
- LS load, ack delayed 5 cycles → op_mem_req/addr stable for 5 cycles, single op_ls_done pulse with ack data.
- TIMEOUT=16, memory never acks → op_ls_done=1 and op_ls_err=1 exactly 16 cycles after op_mem_req rose; IDLE next cycle.
- ip_rst asserted during BUSY_IF with ack pending → all outputs 0 next cycle, no done pulse, new IF request served normally after reset.
- IF req held continuously with ack every cycle → done every 2 cycles, no duplicate grant in done cycle.
